// File: rtl/store_write_buffer.sv
// Store write buffer: aligns MEM-stage stores into word-addressed entries with byte
// enables, queues them in a small FIFO and drains them to data memory over valid/ready.
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [31:0]   st_addr,
  input  logic [31:0]   st_data,
  input  logic [1:0]    st_type,
  output logic          st_err,
  output logic [31:0]   st_err_addr,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [31:0]   ld_addr,
  output logic          ld_hit,
  output logic [AW:0]   count
);

  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_BYTE = 2'b01;
  localparam logic [1:0] TYPE_HALF = 2'b10;
  localparam logic [1:0] TYPE_WORD = 2'b11;

  logic [29:0]   ent_addr_q  [DEPTH];
  logic [29:0]   ent_addr_d  [DEPTH];
  logic [31:0]   ent_wdata_q [DEPTH];
  logic [31:0]   ent_wdata_d [DEPTH];
  logic [3:0]    ent_be_q    [DEPTH];
  logic [3:0]    ent_be_d    [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          st_err_q, st_err_d;
  logic [31:0]   st_err_addr_q, st_err_addr_d;

  logic          accept_s, misaligned_s, enq_s, deq_s;
  logic [31:0]   new_wdata_s;
  logic [3:0]    new_be_s;
  logic [AW-1:0] off_s;
  logic          hit_s;

  assign st_ready    = (count_q != (AW+1)'(DEPTH));
  assign mem_valid   = (count_q != {(AW+1){1'b0}});
  assign mem_addr    = {ent_addr_q[rd_ptr_q], 2'b00};
  assign mem_wdata   = ent_wdata_q[rd_ptr_q];
  assign mem_be      = ent_be_q[rd_ptr_q];
  assign st_err      = st_err_q;
  assign st_err_addr = st_err_addr_q;
  assign count       = count_q;
  assign ld_hit      = hit_s;

  // Request decode and lane formatting of the incoming store
  always_comb begin
    misaligned_s = 1'b0;
    new_wdata_s  = st_data;
    new_be_s     = 4'b0000;
    case (st_type)
      TYPE_BYTE: begin
        new_wdata_s = {4{st_data[7:0]}};
        new_be_s    = 4'b0001 << st_addr[1:0];
      end
      TYPE_HALF: begin
        misaligned_s = st_addr[0];
        new_wdata_s  = {2{st_data[15:0]}};
        new_be_s     = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      TYPE_WORD: begin
        misaligned_s = (st_addr[1:0] != 2'b00);
        new_wdata_s  = st_data;
        new_be_s     = 4'b1111;
      end
      default: begin
        misaligned_s = 1'b0;
        new_wdata_s  = st_data;
        new_be_s     = 4'b0000;
      end
    endcase
    accept_s = st_valid && st_ready;
    enq_s    = accept_s && (st_type != TYPE_NONE) && !misaligned_s;
    deq_s    = mem_valid && mem_ready;
  end

  // Next-state for pointers, occupancy, error report and entry storage
  always_comb begin
    ent_addr_d  = ent_addr_q;
    ent_wdata_d = ent_wdata_q;
    ent_be_d    = ent_be_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (enq_s) begin
      ent_addr_d[wr_ptr_q]  = st_addr[31:2];
      ent_wdata_d[wr_ptr_q] = new_wdata_s;
      ent_be_d[wr_ptr_q]    = new_be_s;
      wr_ptr_d              = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (deq_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({enq_s, deq_s})
      2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
    st_err_d = accept_s && misaligned_s;
    if (st_err_d) begin
      st_err_addr_d = st_addr;
    end else begin
      st_err_addr_d = st_err_addr_q;
    end
  end

  // Pending-store word match; the entry leaving this cycle still counts
  always_comb begin
    hit_s = 1'b0;
    off_s = {AW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      off_s = AW'(i) - rd_ptr_q;
      hit_s = hit_s | (({1'b0, off_s} < count_q) && (ent_addr_q[i] == ld_addr[31:2]));
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      count_q       <= {(AW+1){1'b0}};
      st_err_q      <= 1'b0;
      st_err_addr_q <= 32'h0000_0000;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      st_err_q      <= st_err_d;
      st_err_addr_q <= st_err_addr_d;
    end
  end

  // Entry payload storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    ent_addr_q  <= ent_addr_d;
    ent_wdata_q <= ent_wdata_d;
    ent_be_q    <= ent_be_d;
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Randomized plus directed bench for store_write_buffer against a queue-based
// reference model of the store buffer rules.
module tb_store_write_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_type;
  logic        st_err;
  logic [31:0] st_err_addr;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [AW:0] count;

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_type(st_type),
    .st_err(st_err), .st_err_addr(st_err_addr),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  entry_t      model_q[$];
  logic        exp_err;
  logic [31:0] exp_err_addr;
  int          n_vec  = 0;
  int          n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every DUT output against the model, then advance the model by one clock.
  task automatic cycle();
    logic        hit;
    logic        acc, deq, mis;
    entry_t      e;
    #1;
    hit = 1'b0;
    foreach (model_q[i]) if (model_q[i].addr[31:2] == ld_addr[31:2]) hit = 1'b1;
    check_eq("count",       32'(count),     32'(model_q.size()));
    check_eq("st_ready",    32'(st_ready),  32'(model_q.size() < DEPTH));
    check_eq("mem_valid",   32'(mem_valid), 32'(model_q.size() != 0));
    check_eq("st_err",      32'(st_err),    32'(exp_err));
    check_eq("st_err_addr", st_err_addr,    exp_err_addr);
    check_eq("ld_hit",      32'(ld_hit),    32'(hit));
    if (model_q.size() != 0) begin
      check_eq("mem_addr",  mem_addr,       model_q[0].addr);
      check_eq("mem_wdata", mem_wdata,      model_q[0].wdata);
      check_eq("mem_be",    32'(mem_be),    32'(model_q[0].be));
    end
    if (reset) begin
      model_q.delete();
      exp_err      = 1'b0;
      exp_err_addr = 32'h0;
    end else begin
      acc = st_valid && (model_q.size() < DEPTH);
      deq = (model_q.size() != 0) && mem_ready;
      mis = ((st_type == 2'd2) && (st_addr % 2 != 0)) || ((st_type == 2'd3) && (st_addr % 4 != 0));
      if (deq) void'(model_q.pop_front());
      exp_err = acc && mis;
      if (exp_err) exp_err_addr = st_addr;
      if (acc && !mis && st_type != 2'd0) begin
        e.addr = st_addr & 32'hFFFF_FFFC;
        if (st_type == 2'd1) begin
          e.wdata = (st_data & 32'hFF) * 32'h0101_0101;
          e.be    = 4'(1 << (st_addr % 4));
        end else if (st_type == 2'd2) begin
          e.wdata = (st_data & 32'hFFFF) * 32'h0001_0001;
          e.be    = (st_addr % 4 >= 2) ? 4'hC : 4'h3;
        end else begin
          e.wdata = st_data;
          e.be    = 4'hF;
        end
        model_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    st_valid = v;
    st_type  = t;
    st_addr  = a;
    st_data  = d;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; ld_addr = 32'h0;
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    exp_err = 1'b0; exp_err_addr = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cycle();  // reset state

    // sb to lane 3, drained immediately
    mem_ready = 1'b1;
    drive(1'b1, 2'd1, 32'h0000_1003, 32'h0000_00AB);
    cycle();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    #1;
    check_eq("sb_valid", 32'(mem_valid), 32'd1);
    check_eq("sb_addr",  mem_addr,       32'h0000_1000);
    check_eq("sb_wdata", mem_wdata,      32'hABAB_ABAB);
    check_eq("sb_be",    32'(mem_be),    32'h8);
    cycle();
    check_eq("sb_count0", 32'(count), 32'd0);

    // sh then sw back-to-back, drained in order
    mem_ready = 1'b0;
    drive(1'b1, 2'd2, 32'h0000_2002, 32'h0000_1234); cycle();
    drive(1'b1, 2'd3, 32'h0000_3000, 32'hDEAD_BEEF); cycle();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    #1;
    check_eq("sh_wdata", mem_wdata,    32'h1234_1234);
    check_eq("sh_be",    32'(mem_be),  32'hC);
    mem_ready = 1'b1;
    cycle();
    check_eq("sw_addr",  mem_addr,  32'h0000_3000);
    check_eq("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    cycle();

    // fill to full with five sw, then drain
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd3, 32'h0000_6000 + 32'(i * 4), 32'h1000_0000 + 32'(i));
      cycle();
    end
    check_eq("full_count", 32'(count),    32'd4);
    check_eq("full_ready", 32'(st_ready), 32'd0);
    mem_ready = 1'b1;
    cycle();  // first dequeue, fifth still held
    cycle();  // fifth accepted here
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    repeat (5) cycle();

    // misalignment
    drive(1'b1, 2'd3, 32'h0000_4002, 32'h1); cycle();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    #1;
    check_eq("mis_err",  32'(st_err), 32'd1);
    check_eq("mis_addr", st_err_addr, 32'h0000_4002);
    cycle();
    drive(1'b1, 2'd2, 32'h0000_4001, 32'h2); cycle();
    drive(1'b1, 2'd1, 32'h0000_4003, 32'h3); cycle();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    repeat (2) cycle();

    // load hit
    mem_ready = 1'b0;
    drive(1'b1, 2'd3, 32'h0000_5000, 32'h5); cycle();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    ld_addr = 32'h0000_5003; #1;
    check_eq("ld_hit_same", 32'(ld_hit), 32'd1);
    cycle();
    ld_addr = 32'h0000_5004; cycle();
    mem_ready = 1'b1; ld_addr = 32'h0000_5003; cycle();
    #1;
    check_eq("ld_hit_drained", 32'(ld_hit), 32'd0);
    cycle();

    // simultaneous enqueue/dequeue at count 2
    mem_ready = 1'b0;
    drive(1'b1, 2'd3, 32'h0000_7000, 32'h7); cycle();
    drive(1'b1, 2'd3, 32'h0000_7004, 32'h8); cycle();
    mem_ready = 1'b1;
    drive(1'b1, 2'd3, 32'h0000_7008, 32'h9); cycle();
    check_eq("concurrent_count", 32'(count), 32'd2);

    // reset mid-drain
    mem_ready = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    reset = 1'b1; cycle();
    reset = 1'b0;
    #1;
    check_eq("rst_valid", 32'(mem_valid), 32'd0);
    check_eq("rst_ready", 32'(st_ready),  32'd1);
    cycle();

    // randomized traffic over a narrow address window so load hits occur
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 79) == 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      ld_addr   = 32'h0000_8000 + 32'($urandom_range(0, 31));
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            32'h0000_8000 + 32'($urandom_range(0, 31)), $urandom);
      cycle();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
